// File: rtl/fetch_entry_queue.sv
// Fetch entry types shared with the frontend/ID stage, and the instruction queue
// that decouples them. Exception entries block further pushes until a flush.
package ariane_pkg;
    typedef struct packed {
        logic [2:0]  cf;
        logic [63:0] predict_address;
    } branchpredict_sbe_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]        address;
        logic [31:0]        instruction;
        branchpredict_sbe_t branch_predict;
        exception_t         ex;
    } fetch_entry_t;
endpackage

// Circular-buffer FIFO of fetch entries; ready/valid: a transfer happens on a
// rising edge where valid and ready are both high, valid never waits on ready.
module fetch_entry_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  ariane_pkg::fetch_entry_t       fetch_entry_i,
    input  logic                           fetch_entry_valid_i,
    output logic                           fetch_entry_ready_o,
    output ariane_pkg::fetch_entry_t       fetch_entry_o,
    output logic                           fetch_entry_valid_o,
    input  logic                           fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]         usage_o,
    output logic                           ex_blocked_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ariane_pkg::fetch_entry_t r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ex_blocked;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full              = (r_count == CW'(DEPTH));
    assign fetch_entry_ready_o = !w_full && !r_ex_blocked && !flush_i;
    assign fetch_entry_valid_o = (r_count != '0) && !flush_i;
    assign fetch_entry_o       = r_mem[r_rd_ptr];
    assign usage_o             = r_count;
    assign ex_blocked_o        = r_ex_blocked;

    // ready/valid already exclude flush, so neither transfer can fire in a flush cycle
    assign w_push = fetch_entry_valid_i && fetch_entry_ready_o;
    assign w_pop  = fetch_entry_valid_o && fetch_entry_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_ex_blocked <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_ex_blocked <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && fetch_entry_i.ex.valid) begin
                r_ex_blocked <= 1'b1;
            end
        end
    end

    // Payload storage is not reset; only occupancy state decides what is visible.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fetch_entry_i;
        end
    end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// Randomized and directed bench for fetch_entry_queue against a queue-based
// reference model of the FIFO, exception block, flush and reset behaviour.
module tb_fetch_entry_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic                     flush_i;
    ariane_pkg::fetch_entry_t fetch_entry_i;
    logic                     fetch_entry_valid_i;
    logic                     fetch_entry_ready_o;
    ariane_pkg::fetch_entry_t fetch_entry_o;
    logic                     fetch_entry_valid_o;
    logic                     fetch_entry_ready_i;
    logic [CW-1:0]            usage_o;
    logic                     ex_blocked_o;

    fetch_entry_queue #(.DEPTH(DEPTH)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .fetch_entry_i       (fetch_entry_i),
        .fetch_entry_valid_i (fetch_entry_valid_i),
        .fetch_entry_ready_o (fetch_entry_ready_o),
        .fetch_entry_o       (fetch_entry_o),
        .fetch_entry_valid_o (fetch_entry_valid_o),
        .fetch_entry_ready_i (fetch_entry_ready_i),
        .usage_o             (usage_o),
        .ex_blocked_o        (ex_blocked_o)
    );

    always #5 clk_i = ~clk_i;

    // reference model state
    ariane_pkg::fetch_entry_t model_q[$];
    logic                     model_blocked;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ariane_pkg::fetch_entry_t mk(input logic [63:0] addr, input logic ex);
        ariane_pkg::fetch_entry_t e;
        e                = '0;
        e.address        = addr;
        e.instruction    = $urandom;
        e.ex.valid       = ex;
        e.ex.cause       = ex ? 64'd1 : 64'd0;
        e.branch_predict.predict_address = {32'd0, $urandom};
        return e;
    endfunction

    // Drive inputs just after posedge, check at negedge, advance model at posedge.
    task automatic cycle(input logic fl, input logic v, input ariane_pkg::fetch_entry_t e,
                         input logic rdy);
        logic exp_ready;
        logic exp_valid;
        flush_i             = fl;
        fetch_entry_valid_i = v;
        fetch_entry_i       = e;
        fetch_entry_ready_i = rdy;
        exp_ready = (model_q.size() < DEPTH) && !model_blocked && !fl;
        exp_valid = (model_q.size() != 0) && !fl;
        @(negedge clk_i);
        check_eq("ready_o", 64'(fetch_entry_ready_o), 64'(exp_ready));
        check_eq("valid_o", 64'(fetch_entry_valid_o), 64'(exp_valid));
        check_eq("usage_o", 64'(usage_o), 64'(model_q.size()));
        check_eq("ex_blocked_o", 64'(ex_blocked_o), 64'(model_blocked));
        if (exp_valid) begin
            check_eq("head_address", fetch_entry_o.address, model_q[0].address);
            check_eq("head_instr", 64'(fetch_entry_o.instruction), 64'(model_q[0].instruction));
            check_eq("head_ex_valid", 64'(fetch_entry_o.ex.valid), 64'(model_q[0].ex.valid));
        end
        @(posedge clk_i);
        if (fl) begin
            model_q.delete();
            model_blocked = 1'b0;
        end else begin
            if (exp_valid && rdy) void'(model_q.pop_front());
            if (exp_ready && v) begin
                model_q.push_back(e);
                if (e.ex.valid) model_blocked = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(64'h0, 1'b0), 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid_o"}, 64'(fetch_entry_valid_o), 64'd0);
        check_eq({tag, "_usage_o"}, 64'(usage_o), 64'd0);
        check_eq({tag, "_ex_blocked_o"}, 64'(ex_blocked_o), 64'd0);
    endtask

    initial begin
        rst_i               = 1'b1;
        flush_i             = 1'b0;
        fetch_entry_valid_i = 1'b0;
        fetch_entry_ready_i = 1'b0;
        fetch_entry_i       = '0;
        model_blocked       = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("por");
        rst_i = 1'b0;

        // fill to DEPTH with consumer stalled, fifth entry refused, then drain
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, mk(64'h80 + 64'(4 * i), 1'b0), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h90, 1'b0), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h90, 1'b0), 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, mk(64'h0, 1'b0), 1'b1);
        idle(1);
        check_eq("drained_usage", 64'(usage_o), 64'd0);

        // concurrent push/pop at usage 2 across pointer wrap
        cycle(1'b0, 1'b1, mk(64'h200, 1'b0), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h204, 1'b0), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, mk(64'h208 + 64'(4 * i), 1'b0), 1'b1);
        check_eq("wrap_usage", 64'(usage_o), 64'd2);
        idle(1);
        cycle(1'b1, 1'b0, mk(64'h0, 1'b0), 1'b0);

        // exception entry blocks further pushes; buffered entries still drain
        cycle(1'b0, 1'b1, mk(64'h100, 1'b0), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h104, 1'b1), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h108, 1'b0), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(64'h108, 1'b0), 1'b1);
        check_eq("ex_blocked_held", 64'(ex_blocked_o), 64'd1);
        cycle(1'b1, 1'b0, mk(64'h0, 1'b0), 1'b0);
        idle(2);

        // flush at usage 3 with simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, mk(64'h300 + 64'(4 * i), 1'b0), 1'b0);
        cycle(1'b1, 1'b1, mk(64'h3F0, 1'b0), 1'b1);
        idle(1);
        cycle(1'b0, 1'b1, mk(64'h400, 1'b0), 1'b1);
        idle(2);

        // asynchronous reset mid-fill at usage 2
        cycle(1'b0, 1'b1, mk(64'h500, 1'b0), 1'b0);
        cycle(1'b0, 1'b1, mk(64'h504, 1'b0), 1'b0);
        fetch_entry_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_q.delete();
        model_blocked = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic fl, v, r, ex;
            fl = ($urandom_range(0, 99) < 3);
            v  = ($urandom_range(0, 99) < 70);
            r  = ($urandom_range(0, 99) < 60);
            ex = ($urandom_range(0, 99) < 5);
            cycle(fl, v, mk({$urandom, $urandom}, ex), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
